// File: rtl/div16by8_seq.sv
// Sequential restoring divider: 2*DW-bit unsigned dividend by DW-bit unsigned divisor,
// one quotient bit per clock, MSB first. Divide-by-zero completes in one cycle with dbz set.
module div16by8_seq #(
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2*DW-1:0]   dividend,
  input  logic [DW-1:0]     divisor,
  output logic [2*DW-1:0]   quotient,
  output logic [DW-1:0]     remainder,
  output logic              busy,
  output logic              done,
  output logic              dbz,
  output logic [1:0]        o_dbg_state
);

  // Handshake: start is taken on any rising edge where the FSM is not in CALC (IDLE or DONE);
  // operands are captured on that edge and busy rises with it. done is a single-cycle pulse,
  // and quotient/remainder/dbz are valid from the done cycle until the next done.
  localparam int CW = $clog2(2 * DW);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [2*DW-1:0]     r_dvd;
  logic [DW-1:0]       r_dvs;
  logic [DW-1:0]       r_prem;
  logic [2*DW-1:0]     r_quotient;
  logic [DW-1:0]       r_remainder;
  logic                r_busy;
  logic                r_done;
  logic                r_dbz;

  logic [DW:0]         w_shift;
  logic                w_ge;
  logic [DW-1:0]       w_diff;
  logic [DW-1:0]       w_prem_next;
  logic [2*DW-1:0]     w_quot_next;
  logic                w_last;

  // The 9-bit trial value never exceeds 2*divisor-1, so the low DW bits of the
  // difference are exact whenever the subtraction is kept.
  assign w_shift     = {r_prem, r_dvd[2*DW-1]};
  assign w_ge        = (w_shift >= {1'b0, r_dvs});
  assign w_diff      = w_shift[DW-1:0] - r_dvs;
  assign w_prem_next = w_ge ? w_diff : w_shift[DW-1:0];
  assign w_quot_next = {r_dvd[2*DW-2:0], w_ge};
  assign w_last      = (r_cnt == CW'(2 * DW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_prem      <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_dvd   <= dividend;
            r_dvs   <= divisor;
            r_prem  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CALC;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          if (r_dvs == '0) begin
            r_quotient  <= '1;
            r_remainder <= r_dvd[DW-1:0];
            r_dbz       <= 1'b1;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_DONE;
          end else begin
            r_prem <= w_prem_next;
            r_dvd  <= w_quot_next;
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) begin
              r_quotient  <= w_quot_next;
              r_remainder <= w_prem_next;
              r_dbz       <= 1'b0;
              r_done      <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= S_DONE;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign busy        = r_busy;
  assign done        = r_done;
  assign dbz         = r_dbz;
  assign o_dbg_state = r_state;

endmodule
